// File: rtl/gpio_ctrl_if.sv
// gpio_ctrl_if: single-cycle load/store bus between the core data controller and gpio_ctrl
interface gpio_ctrl_if;
  logic [31:0] wdata;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        we;
  modport master (output wdata, addr, we, input rdata);
  modport slave (input wdata, addr, we, output rdata);
endinterface

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO with edge-event status and level irq; define GPIO_DEBOUNCE_EN for per-pin debounce
module gpio_ctrl #(
  parameter int N = 8,
  parameter int DB_CYCLES = 4
) (
  input  logic         clk,
  input  logic         arst_n,
  gpio_ctrl_if.slave   bus,
  input  logic [N-1:0] gpio_i,
  output logic [N-1:0] gpio_o,
  output logic [N-1:0] gpio_oe,
  output logic         irq
);
  logic [N-1:0] out_r, dir_r, rise_r, fall_r, ien_r, stat_r;
  logic [N-1:0] s1, s2, filt, prev, wd, ev, rsel;
  logic [2:0] a;
  logic [7:0] wr;
  logic unused_bits;
  assign a = bus.addr[4:2];
  assign wd = bus.wdata[N-1:0];
  assign wr = bus.we ? 8'(1) << a : 8'd0;
  assign ev = (filt & ~prev & rise_r) | (~filt & prev & fall_r);
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      {out_r, dir_r, rise_r, fall_r, ien_r, stat_r, s1, s2, prev} <= '0;
    end else begin
      out_r <= wr[0] ? wd : out_r;
      dir_r <= wr[1] ? wd : dir_r;
      rise_r <= wr[3] ? wd : rise_r;
      fall_r <= wr[4] ? wd : fall_r;
      ien_r <= wr[5] ? wd : ien_r;
      // a new event wins over a same-cycle W1C of that bit
      stat_r <= (stat_r & ~(wd & {N{wr[6]}})) | ev;
      s1 <= gpio_i;
      s2 <= s1;
      prev <= filt;
    end
  end
  always_comb begin
    case (a)
      3'd0: rsel = out_r;
      3'd1: rsel = dir_r;
      3'd2: rsel = filt;
      3'd3: rsel = rise_r;
      3'd4: rsel = fall_r;
      3'd5: rsel = ien_r;
      3'd6: rsel = stat_r;
      default: rsel = '0;
    endcase
  end
  assign bus.rdata = 32'(rsel);
  assign gpio_o = out_r;
  assign gpio_oe = dir_r;
  assign irq = |(stat_r & ien_r);
`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES);
  logic [CW-1:0] cnt [N];
  // filt follows s2 only after DB_CYCLES consecutive edges of disagreement
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!arst_n) begin
        cnt[i] <= '0;
        filt[i] <= 1'b0;
      end else if (s2[i] == filt[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
        filt[i] <= s2[i];
        cnt[i] <= '0;
      end else begin
        cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end
  assign unused_bits = ^{bus.addr[31:5], bus.addr[1:0], bus.wdata};
`else
  assign filt = s2;
  assign unused_bits = ^{bus.addr[31:5], bus.addr[1:0], bus.wdata, DB_CYCLES[0]};
`endif
endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed + random checks of gpio_ctrl against a pin-history reference model
module tb_gpio_ctrl;
  localparam int N = 8;
  localparam int DB = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = DB;
`else
  localparam int LAT = 0;
`endif
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic [N-1:0] gpio_i = '0;
  logic [N-1:0] gpio_o, gpio_oe;
  logic irq;
  int n_chk = 0;
  int n_fail = 0;
  logic [N-1:0] m_reg [8];
  logic [N-1:0] hist [DB+2];
  logic [N-1:0] m_filt, m_prev;
  logic [31:0] v;
  gpio_ctrl_if bus();
  gpio_ctrl #(.N(N), .DB_CYCLES(DB)) dut (
    .clk(clk), .arst_n(arst_n), .bus(bus.slave),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
  );
  always #50 clk = ~clk;
  // reference: registers as an array, pins as a sample history
  always @(posedge clk) begin
    logic [N-1:0] ev;
    logic [2:0] ra;
    logic all_new;
    ra = bus.addr[4:2];
    if (!arst_n) begin
      foreach (m_reg[i]) m_reg[i] = '0;
      foreach (hist[i]) hist[i] = '0;
      m_filt = '0;
      m_prev = '0;
    end else begin
      ev = (m_filt & ~m_prev & m_reg[3]) | (~m_filt & m_prev & m_reg[4]);
      if (bus.we && ra inside {3'd0, 3'd1, 3'd3, 3'd4, 3'd5}) m_reg[ra] = bus.wdata[N-1:0];
      if (bus.we && ra == 3'd6) m_reg[6] = m_reg[6] & ~bus.wdata[N-1:0];
      m_reg[6] = m_reg[6] | ev;
      m_prev = m_filt;
      for (int i = DB + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = gpio_i;
`ifdef GPIO_DEBOUNCE_EN
      for (int b = 0; b < N; b++) begin
        all_new = 1'b1;
        for (int j = 2; j <= DB + 1; j++) if (hist[j][b] == m_filt[b]) all_new = 1'b0;
        if (all_new) m_filt[b] = ~m_filt[b];
      end
`else
      all_new = 1'b0;
      m_filt = hist[1];
`endif
    end
  end
  function automatic logic [31:0] m_rd(input logic [2:0] ra);
    return ra == 3'd2 ? 32'(m_filt) : ra == 3'd7 ? 32'd0 : 32'(m_reg[ra]);
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic wr(input int ra, input logic [31:0] d);
    bus.addr = 32'(ra) << 2;
    bus.wdata = d;
    bus.we = 1'b1;
    tick();
    bus.we = 1'b0;
  endtask
  task automatic rd(input int ra, output logic [31:0] d);
    bus.addr = 32'(ra) << 2;
    #1 d = bus.rdata;
  endtask
  task automatic chk_reg(input string tag, input int ra, input logic [31:0] exp);
    logic [31:0] d;
    rd(ra, d);
    check(tag, d, exp);
  endtask
  task automatic chk_model(input string tag);
    logic [31:0] d;
    check({tag, ".gpio_o"}, 32'(gpio_o), 32'(m_reg[0]));
    check({tag, ".gpio_oe"}, 32'(gpio_oe), 32'(m_reg[1]));
    check({tag, ".irq"}, 32'(irq), 32'(|(m_reg[6] & m_reg[5])));
    for (int i = 0; i < 8; i++) begin
      rd(i, d);
      check($sformatf("%s.rd%0d", tag, i), d, m_rd(3'(i)));
    end
  endtask
  initial begin
    int c;
    bus.we = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    @(negedge clk);
    bus.we = 1'b1;
    bus.wdata = 32'hFF;
    tick();
    tick();
    bus.we = 1'b0;
    arst_n = 1'b1;
    for (int i = 0; i < 8; i++) if (i != 2) chk_reg($sformatf("rst.rd%0d", i), i, 32'd0);
    check("rst.gpio_oe", 32'(gpio_oe), 32'd0);
    check("rst.gpio_o", 32'(gpio_o), 32'd0);
    check("rst.irq", 32'(irq), 32'd0);
    chk_model("rst");
    wr(1, 32'hABCD_12F0);
    check("out.gpio_oe", 32'(gpio_oe), 32'hF0);
    wr(0, 32'hA5);
    check("out.gpio_o", 32'(gpio_o), 32'hA5);
    chk_reg("out.dir", 1, 32'h0000_00F0);
    chk_reg("out.out", 0, 32'h0000_00A5);
    wr(2, 32'hFF);
    wr(7, 32'hFF);
    chk_reg("ro.in", 2, 32'd0);
    chk_reg("ro.a7", 7, 32'd0);
    chk_model("out");
    wr(3, 32'h01);
    wr(5, 32'h01);
    gpio_i[0] = 1'b1;
    tick();
    chk_reg("rise.in_k", 2, 32'd0);
    repeat (LAT) tick();
    tick();
    chk_reg("rise.in_k1", 2, 32'h01);
    chk_reg("rise.stat_k1", 6, 32'd0);
    check("rise.irq_k1", 32'(irq), 32'd0);
    tick();
    chk_reg("rise.stat_k2", 6, 32'h01);
    check("rise.irq_k2", 32'(irq), 32'd1);
    gpio_i[0] = 1'b0;
    repeat (LAT + 3) tick();
    gpio_i[0] = 1'b1;
    tick();
    repeat (LAT) tick();
    tick();
    wr(6, 32'h01);
    chk_reg("w1c.collide", 6, 32'h01);
    wr(6, 32'h01);
    chk_reg("w1c.clear", 6, 32'h00);
    check("w1c.irq", 32'(irq), 32'd0);
    chk_model("w1c");
    gpio_i[1] = 1'b1;
    wr(4, 32'h02);
    wr(5, 32'h00);
    repeat (LAT + 3) tick();
    gpio_i[1] = 1'b0;
    repeat (LAT + 3) tick();
    chk_reg("mask.stat", 6, 32'h02);
    check("mask.irq0", 32'(irq), 32'd0);
    wr(5, 32'h02);
    check("mask.irq1", 32'(irq), 32'd1);
    wr(6, 32'h02);
    wr(3, 32'h04);
    gpio_i[2] = 1'b1;
    repeat (3) tick();
    gpio_i[2] = 1'b0;
    repeat (LAT + 4) tick();
    chk_reg("glitch.stat", 6, LAT == 0 ? 32'h04 : 32'h00);
    chk_reg("glitch.in", 2, 32'h01);
    wr(6, 32'h04);
    gpio_i[2] = 1'b1;
    c = 0;
    bus.addr = 32'd8;
    do begin
      tick();
      c++;
    end while (bus.rdata[2] !== 1'b1 && c < 20);
    check("stable.latency", 32'(c), 32'(LAT + 2));
    chk_model("stable");
    for (int k = 0; k < 400; k++) begin
      arst_n = ($urandom_range(99) != 0);
      bus.we = ($urandom_range(2) == 0);
      bus.addr = $urandom;
      bus.wdata = $urandom;
      if ($urandom_range(3) == 0) gpio_i = gpio_i ^ N'($urandom);
      tick();
      bus.we = 1'b0;
      check("rnd.gpio_o", 32'(gpio_o), 32'(m_reg[0]));
      check("rnd.gpio_oe", 32'(gpio_oe), 32'(m_reg[1]));
      check("rnd.irq", 32'(irq), 32'(|(m_reg[6] & m_reg[5])));
      #1 v = bus.rdata;
      check($sformatf("rnd.rd%0d", bus.addr[4:2]), v, m_rd(bus.addr[4:2]));
    end
    arst_n = 1'b1;
    tick();
    chk_model("end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gpio_ctrl.md
GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 SHALL have parameter N, default 8: channel count, legal range 1..32.
REQ-002 SHALL have parameter DB_CYCLES, default 4: debounce stability length in clocks, legal range 2..255, used only with GPIO_DEBOUNCE_EN.
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port arst_n, input, 1 bit: synchronous active-low reset, sampled on the clk rising edge.
REQ-005 SHALL have port wdata, input, 32 bits: store data from the core.
REQ-006 SHALL have port addr, input, 32 bits: byte address; only addr[4:2] is decoded.
REQ-007 SHALL have port we, input, 1 bit: write strike, already chip-selected by the data controller.
REQ-008 SHALL have port rdata, output, 32 bits: combinational read data, zero-extended above N.
REQ-009 SHALL have port gpio_i, input, N bits: asynchronous pin inputs.
REQ-010 SHALL have port gpio_o, output, N bits: pin output values.
REQ-011 SHALL have port gpio_oe, output, N bits: per-pin output enable; the top level builds the tristates.
REQ-012 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-013 SHALL decode the register map on addr[4:2] as follows:
- 0 = OUT (RW)
- 1 = DIR (RW, 1 = output)
- 2 = IN (RO)
- 3 = RISE (RW, rising-edge mask)
- 4 = FALL (RW, falling-edge mask)
- 5 = IEN (RW)
- 6 = STAT (W1C)
- 7 = unmapped.
REQ-014 SHALL update RW registers on the clk edge where we=1, from wdata[N-1:0].
REQ-015 SHALL ignore writes to IN and to address 7; reads of address 7 SHALL return 0.
REQ-016 SHALL drive rdata combinationally from addr[4:2] with zero-cycle read latency, so a single-cycle lw completes.
REQ-017 SHALL drive gpio_o = OUT and gpio_oe = DIR directly from the registers.
REQ-018 SHALL pass gpio_i through a 2-flop synchronizer (s1, s2) per channel.
REQ-019 SHALL return the filtered value filt in IN; IN reflects the pin regardless of DIR (loopback).
REQ-020 SHALL hold a prev register per channel, loaded with filt every clock.
REQ-021 SHALL detect a rising event when filt=1 and prev=0, and a falling event when filt=0 and prev=1.
REQ-022 SHALL set STAT[k] on the next edge when (rise_k & RISE[k]) | (fall_k & FALL[k]), independent of IEN.
REQ-023 SHALL clear a STAT bit when a 1 is written to it at address 6; writing 0 leaves the bit unchanged.
REQ-024 SHALL give set priority over W1C when a set and a W1C hit the same bit in the same cycle, leaving the bit at 1.
REQ-025 SHALL drive irq = |(STAT & IEN) combinationally, with no extra latency after STAT or IEN changes.
REQ-026 SHALL meet this latency without debounce: pin change before edge k gives IN valid after edge k+1, STAT set after edge k+2, irq high after edge k+2.
REQ-027 SHALL make pulses shorter than one clock non-detectable; no guarantee is given for them.

Reset
REQ-028 SHALL, while arst_n=0 at a clk edge, clear to 0:
- OUT, DIR, RISE, FALL, IEN, STAT
- s1, s2, filt, prev
- debounce counters.
REQ-029 SHALL, after reset, read gpio_o=0, gpio_oe=0 (all inputs), irq=0 and rdata=0 for every address except IN.
REQ-030 SHALL give reset priority over a concurrent write, and SHALL discard an in-progress debounce count.
REQ-031 SHALL record no event for a pin held high through reset release, because RISE=0 after reset.

Configuration
REQ-032 SHALL use macro GPIO_DEBOUNCE_EN to select the filter behaviour.
REQ-033 SHALL, when GPIO_DEBOUNCE_EN is undefined, make filt = s2 and synthesize no counters.
REQ-034 SHALL, when GPIO_DEBOUNCE_EN is defined, give each channel a counter of width clog2(DB_CYCLES) with these rules:
- s2 == filt: counter cleared.
- s2 != filt: counter increments.
- Counter reaches DB_CYCLES-1 while s2 != filt: filt <= s2 and counter cleared on that edge.
REQ-035 SHALL, with debounce enabled, delay IN and STAT by exactly DB_CYCLES edges beyond the no-debounce latency.
REQ-036 SHALL, with debounce enabled, produce no filt change for a glitch shorter than DB_CYCLES clocks.

Verification
REQ-037 SHALL verify reset values: N=8; drive arst_n=0 for 2 clocks, then read all 8 addresses -> every rdata=0 except IN, gpio_oe=0x00, irq=0.
REQ-038 SHALL verify output path: write DIR=0xF0 then OUT=0xA5 -> gpio_oe=0xF0 and gpio_o=0xA5 the cycle after each write; readback of DIR=0x000000F0 and OUT=0x000000A5.
REQ-039 SHALL verify rising-edge interrupt: RISE=0x01, IEN=0x01; gpio_i[0] 0->1 before edge k -> IN[0]=1 after edge k+1, STAT=0x01 and irq=1 after edge k+2.
REQ-040 SHALL verify W1C and collision: write STAT=0x01 on the same cycle a new rise on bit 0 is detected -> STAT stays 0x01; a later W1C with 0x01 -> STAT=0x00 and irq=0.
REQ-041 SHALL verify event masking: FALL=0x02, IEN=0x00; gpio_i[1] 1->0 -> STAT=0x02 and irq=0; then write IEN=0x02 -> irq=1 combinationally.
REQ-042 SHALL verify debounce filtering (GPIO_DEBOUNCE_EN, DB_CYCLES=4): a 3-clock high glitch on gpio_i[2] -> no STAT change; a 4-clock stable high -> IN[2]=1 exactly 4 edges later than the no-debounce case.
